spi_slave_gen: RTL and testbench
================================

# spi_slave_gen

Parametrised SPI slave front-end for the SPI-to-RAM path. It deserialises MOSI frames of DATA_W+2 bits into a command+payload word for the RAM controller. It serialises RAM read data back on MISO. Beyond the fixed 8-bit slave, it generalises data width and bit order, supports back-to-back frames under one SS_n assertion, and waits on a tx_valid handshake before driving read data.

## Interface
- DATA_W, 8: payload width; rx_data is DATA_W+2 bits, tx_data is DATA_W bits (DATA_W >= 2).
- MSB_FIRST, 1: 1 = MSB shifted first on MOSI and MISO; 0 = LSB first (command bits still transferred first).
- clk  input  1  single system clock; all MOSI/SS_n sampling on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- SS_n  input  1  slave select, active low.
- MOSI  input  1  serial data in.
- MISO  output  1  serial data out, registered.
- rx_data  output  DATA_W+2  {cmd[1:0], payload}; cmd 00 write-addr, 01 write-data, 10 read-addr, 11 read-data.
- rx_valid  output  1  one-cycle pulse when rx_data is valid.
- tx_data  input  DATA_W  read data from RAM.
- tx_valid  input  1  tx_data qualifier; sampled only in READ_WAIT.
- rx_err  output  1  parity error pulse, coincident with rx_valid (constant 0 without SPI_SLAVE_PARITY_EN).

## Operation
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, READ_WAIT, READ_TX.
- IDLE -> CHK_CMD on an edge with SS_n=0.
- CHK_CMD samples the selector bit:
  - 0 -> WRITE.
  - 1 with rd_addr_seen=0 -> READ_ADD.
  - 1 with rd_addr_seen=1 -> READ_DATA.
- The selector bit is not stored in rx_data.
- WRITE/READ_ADD/READ_DATA shift DATA_W+2 MOSI bits into rx_data.
  - The first two bits are cmd[1], cmd[0].
  - Payload order follows MSB_FIRST.
- The cmd field is passed through unchecked; the next state is chosen by the selector only.
- READ_ADD completion sets rd_addr_seen. READ_DATA completion clears it and enters READ_WAIT.
- WRITE/READ_ADD completion:
  - SS_n=0 -> CHK_CMD; the next edge samples a new selector (burst mode).
  - SS_n=1 -> IDLE.
- READ_WAIT:
  - On an edge with tx_valid=1, capture tx_data and go to READ_TX.
  - tx_valid is ignored in all other states.
- READ_TX drives DATA_W bits on MISO, then goes to CHK_CMD if SS_n=0, else IDLE.
- MISO is 0 outside READ_TX.
- SS_n=1 sampled in any non-IDLE state:
  - Go to IDLE next edge.
  - Clear the bit counter and shift register.
  - No rx_valid is produced.
  - rd_addr_seen is unchanged.
- Reset values: MISO=0, rx_data=0, rx_valid=0, rx_err=0, rd_addr_seen=0, state IDLE.

## Timing
- Edge 0: SS_n=0 seen in IDLE.
- Edge 1: selector sampled.
- Edges 2..DATA_W+3: data bits sampled.
- rx_valid and rx_data update on edge DATA_W+3 (edge 11 for DATA_W=8); rx_valid is high for exactly one cycle.
- Burst: the next selector is sampled at edge DATA_W+4; rx_valid pulses are DATA_W+3 cycles apart.
- READ_TX: the first MISO bit is registered on the edge that samples tx_valid=1. Each later bit updates on the following edges. MISO returns to 0 after DATA_W cycles.
- An abort on the same edge as the last data bit wins: no rx_valid.

## Configuration
- SPI_SLAVE_PARITY_EN defined:
  - Each receive frame carries one extra odd-parity bit after the DATA_W+2 data bits, which delays rx_valid by one cycle.
  - rx_err=1 with rx_valid if the XOR of all DATA_W+3 bits is 0.
  - READ_TX appends an odd-parity bit after the DATA_W data bits.
- SPI_SLAVE_PARITY_EN undefined: no parity bits; rx_err is constant 0.

## Test plan
- Reset: hold rst_n=0 mid-frame -> MISO=0, rx_valid=0, rx_data=10'h000 immediately (async); the next frame decodes normally.
- Write-addr: SS_n=0, selector 0, bits 00_1010_0101 -> rx_data=10'h0A5, rx_valid high exactly at edge 11 for one cycle.
- Read sequence:
  - Selector 1, bits 10_0011_0000 -> rx_data=10'h230.
  - Next frame: selector 1, bits 11_0000_0000 -> READ_WAIT.
  - tx_valid=1 with tx_data=8'hC3 two cycles later -> MISO 1,1,0,0,0,0,1,1.
  - rd_addr_seen is then 0.
- Burst: SS_n held low across two write frames (10'h0A5, 10'h15A) -> two rx_valid pulses 11 cycles apart, with the correct rx_data each.
- Abort: SS_n=1 after 5 data bits -> no rx_valid, state IDLE; the following full frame 10'h0FF is received correctly.
- With SPI_SLAVE_PARITY_EN, DATA_W=8: frame 10'h0A5 with parity bit 1 -> rx_valid at edge 12 with rx_err=0; parity bit 0 -> rx_err=1.

Source files
------------

// File: rtl/spi_slave_gen_if.sv
// Bus bundle between the SPI slave front-end and its environment (pins + RAM side).
// The slave modport is the DUT view; master is the driving side (pads/RAM model).
interface spi_slave_gen_if #(
    parameter int DATA_W = 8
) ();
    logic              SS_n;
    logic              MOSI;
    logic              MISO;
    logic [DATA_W+1:0] rx_data;
    logic              rx_valid;
    logic              rx_err;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;

    modport slave (
        input  SS_n,
        input  MOSI,
        input  tx_data,
        input  tx_valid,
        output MISO,
        output rx_data,
        output rx_valid,
        output rx_err
    );

    modport master (
        output SS_n,
        output MOSI,
        output tx_data,
        output tx_valid,
        input  MISO,
        input  rx_data,
        input  rx_valid,
        input  rx_err
    );
endinterface

// File: rtl/spi_slave_gen.sv
// Parametrised SPI slave: deserialises {cmd, payload} frames and serialises RAM read data.
// Optional odd-parity framing on both directions is enabled by defining SPI_SLAVE_PARITY_EN.
module spi_slave_gen #(
    parameter int DATA_W    = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input logic            clk,
    input logic            rst_n,
    spi_slave_gen_if.slave bus
);

`ifdef SPI_SLAVE_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int DATA_BITS  = DATA_W + 2;
    localparam int FRAME_BITS = DATA_BITS + PAR_BITS;
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);
    localparam int TXC_W      = $clog2(DATA_W + PAR_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_CMD_END  = CNT_W'(2);
    localparam logic [CNT_W-1:0] CNT_DATA_END = CNT_W'(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [TXC_W-1:0] TXC_DATA_END = TXC_W'(DATA_W);
    localparam logic [TXC_W-1:0] TXC_LAST     = TXC_W'(DATA_W + PAR_BITS);
    localparam logic [TXC_W-1:0] TXC_ONE      = TXC_W'(1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4,
        READ_WAIT = 3'd5,
        READ_TX   = 3'd6
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [1:0]          cmd_q;
    logic [DATA_W-1:0]   pay_q;
    logic [DATA_W-1:0]   pay_d;
    logic [DATA_W+1:0]   rx_data_q;
    logic                rx_valid_q;
    logic                rx_err_q;
    logic                rd_addr_seen_q;
    logic [DATA_W-1:0]   tx_sh_q;
    logic [TXC_W-1:0]    tx_cnt_q;
    logic                tx_par_q;
    logic                miso_q;
    logic [DATA_W+1:0]   frame_word_s;
    logic                frame_err_s;

    function automatic logic odd_parity(input logic [DATA_W-1:0] d);
        return ~(^d);
    endfunction

    function automatic logic head_bit(input logic [DATA_W-1:0] d);
        return MSB_FIRST ? d[DATA_W-1] : d[0];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] d);
        return MSB_FIRST ? {d[DATA_W-2:0], 1'b0} : {1'b0, d[DATA_W-1:1]};
    endfunction

    // Next payload value with the current MOSI bit inserted in transfer order.
    always_comb begin
        pay_d = pay_q;
        if (MSB_FIRST) begin
            pay_d = {pay_q[DATA_W-2:0], bus.MOSI};
        end else begin
            pay_d = {bus.MOSI, pay_q[DATA_W-1:1]};
        end
    end

    // With parity the final edge carries the parity bit, so the word is already complete.
`ifdef SPI_SLAVE_PARITY_EN
    assign frame_word_s = {cmd_q, pay_q};
    assign frame_err_s  = ~(^{cmd_q, pay_q, bus.MOSI});
`else
    assign frame_word_s = {cmd_q, pay_d};
    assign frame_err_s  = 1'b0;
`endif

    // Frame sequencer: receive shifting, read handshake and MISO serialisation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            cmd_q          <= 2'b00;
            pay_q          <= '0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            rx_err_q       <= 1'b0;
            rd_addr_seen_q <= 1'b0;
            tx_sh_q        <= '0;
            tx_cnt_q       <= '0;
            tx_par_q       <= 1'b0;
            miso_q         <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    miso_q <= 1'b0;
                    if (!bus.SS_n) begin
                        state_q <= CHK_CMD;
                    end else begin
                        state_q <= IDLE;
                    end
                end

                CHK_CMD: begin
                    miso_q <= 1'b0;
                    cnt_q  <= '0;
                    cmd_q  <= 2'b00;
                    pay_q  <= '0;
                    if (bus.SS_n) begin
                        state_q <= IDLE;
                    end else if (!bus.MOSI) begin
                        state_q <= WRITE;
                    end else if (rd_addr_seen_q) begin
                        state_q <= READ_DATA;
                    end else begin
                        state_q <= READ_ADD;
                    end
                end

                WRITE, READ_ADD, READ_DATA: begin
                    miso_q <= 1'b0;
                    if (bus.SS_n) begin
                        // Deselect mid-frame drops the partial word, even on its last bit.
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        cmd_q   <= 2'b00;
                        pay_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                        if (cnt_q < CNT_CMD_END) begin
                            cmd_q <= {cmd_q[0], bus.MOSI};
                        end else if (cnt_q < CNT_DATA_END) begin
                            pay_q <= pay_d;
                        end else begin
                            pay_q <= pay_q;
                        end
                        if (cnt_q == CNT_LAST) begin
                            rx_valid_q <= 1'b1;
                            rx_data_q  <= frame_word_s;
                            rx_err_q   <= frame_err_s;
                            cnt_q      <= '0;
                            case (state_q)
                                READ_ADD: begin
                                    rd_addr_seen_q <= 1'b1;
                                    state_q        <= CHK_CMD;
                                end
                                READ_DATA: begin
                                    rd_addr_seen_q <= 1'b0;
                                    state_q        <= READ_WAIT;
                                end
                                default: begin
                                    state_q <= CHK_CMD;
                                end
                            endcase
                        end else begin
                            state_q <= state_q;
                        end
                    end
                end

                READ_WAIT: begin
                    if (bus.SS_n) begin
                        miso_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (bus.tx_valid) begin
                        miso_q   <= head_bit(bus.tx_data);
                        tx_sh_q  <= shift_out(bus.tx_data);
                        tx_par_q <= odd_parity(bus.tx_data);
                        tx_cnt_q <= TXC_ONE;
                        state_q  <= READ_TX;
                    end else begin
                        miso_q  <= 1'b0;
                        state_q <= READ_WAIT;
                    end
                end

                READ_TX: begin
                    if (bus.SS_n) begin
                        miso_q   <= 1'b0;
                        tx_cnt_q <= '0;
                        state_q  <= IDLE;
                    end else if (tx_cnt_q < TXC_DATA_END) begin
                        miso_q   <= head_bit(tx_sh_q);
                        tx_sh_q  <= shift_out(tx_sh_q);
                        tx_cnt_q <= tx_cnt_q + TXC_ONE;
                    end else if (tx_cnt_q < TXC_LAST) begin
                        miso_q   <= tx_par_q;
                        tx_cnt_q <= tx_cnt_q + TXC_ONE;
                    end else begin
                        miso_q   <= 1'b0;
                        tx_cnt_q <= '0;
                        state_q  <= CHK_CMD;
                    end
                end

                default: begin
                    miso_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.MISO     = miso_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.rx_err   = rx_err_q;

endmodule

// File: tb/tb_spi_slave_gen.sv
// Directed bench for spi_slave_gen (DATA_W=8, MSB first): write, read, burst, abort, reset.
module tb_spi_slave_gen;
    localparam int DW = 8;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;

    spi_slave_gen_if #(.DATA_W(DW)) bus ();

    spi_slave_gen #(.DATA_W(DW), .MSB_FIRST(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        @(negedge clk);
        bus.SS_n = 1'b0;
        bus.MOSI = b;
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        @(negedge clk);
        bus.SS_n = 1'b0;
        bus.MOSI = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic end_frame(input string tag);
        @(negedge clk);
        bus.SS_n = 1'b1;
        bus.MOSI = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "_nv"}, 32'(bus.rx_valid), 32'd0);
    endtask

    // Selector + 10 frame bits (+ parity when enabled); checks pulse timing and data.
    task automatic frame(input string tag, input logic sel, input logic [9:0] bits,
                         input logic par_good, input logic [9:0] exp_data);
        logic exp_err;
        drive_bit(sel);
        chk({tag, "_sel_nv"}, 32'(bus.rx_valid), 32'd0);
        for (int i = 9; i >= 0; i--) begin
            drive_bit(bits[i]);
`ifndef SPI_SLAVE_PARITY_EN
            if (i == 1) chk({tag, "_early"}, 32'(bus.rx_valid), 32'd0);
`endif
        end
`ifdef SPI_SLAVE_PARITY_EN
        chk({tag, "_early"}, 32'(bus.rx_valid), 32'd0);
        drive_bit(par_good ? ~(^bits) : ^bits);
        exp_err = ~par_good;
`else
        exp_err = 1'b0 & par_good;
`endif
        chk({tag, "_valid"}, 32'(bus.rx_valid), 32'd1);
        chk({tag, "_data"}, 32'(bus.rx_data), 32'(exp_data));
        chk({tag, "_err"}, 32'(bus.rx_err), 32'(exp_err));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] exp_miso;
        n_chk    = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        bus.SS_n = 1'b1;
        bus.MOSI = 1'b0;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_miso", 32'(bus.MISO), 32'd0);
        chk("rst_valid", 32'(bus.rx_valid), 32'd0);
        chk("rst_data", 32'(bus.rx_data), 32'h000);
        chk("rst_err", 32'(bus.rx_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);

        // Write-addr frame
        start_frame();
        frame("wa", 1'b0, 10'b00_1010_0101, 1'b1, 10'h0A5);
        end_frame("wa_end");

        // Async reset mid-frame, then normal decode
        start_frame();
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("amid_miso", 32'(bus.MISO), 32'd0);
        chk("amid_valid", 32'(bus.rx_valid), 32'd0);
        chk("amid_data", 32'(bus.rx_data), 32'h000);
        @(negedge clk);
        bus.SS_n = 1'b1;
        rst_n    = 1'b1;
        @(posedge clk);
        start_frame();
        frame("post_rst", 1'b0, 10'b01_1110_0111, 1'b1, 10'h1E7);
        end_frame("post_rst_end");

        // Read sequence; tx_valid held during READ_ADD must be ignored
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'hFF;
        start_frame();
        frame("ra", 1'b1, 10'b10_0011_0000, 1'b1, 10'h230);
        chk("ra_miso", 32'(bus.MISO), 32'd0);
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        frame("rd", 1'b1, 10'b11_0000_0000, 1'b1, 10'h300);
        drive_bit(1'b0);
        chk("rw_miso", 32'(bus.MISO), 32'd0);
        @(negedge clk);
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'hC3;
        @(posedge clk);
        #1;
        exp_miso = 8'b1100_0011;
        chk("tx_b7", 32'(bus.MISO), 32'(exp_miso[7]));
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        for (int k = 6; k >= 0; k--) begin
            drive_bit(1'b0);
            chk($sformatf("tx_b%0d", k), 32'(bus.MISO), 32'(exp_miso[k]));
        end
`ifdef SPI_SLAVE_PARITY_EN
        drive_bit(1'b0);
        chk("tx_par", 32'(bus.MISO), 32'd1);
`endif
        drive_bit(1'b0);
        chk("tx_done", 32'(bus.MISO), 32'd0);
        // rd_addr_seen must be clear: selector 1 is a read-addr again, so a write follows
        frame("ra2", 1'b1, 10'b10_1010_1010, 1'b1, 10'h2AA);
        frame("wd2", 1'b0, 10'b01_0101_0101, 1'b1, 10'h155);
        end_frame("rd_end");

        // Burst of two write frames under one SS_n
        start_frame();
        frame("b1", 1'b0, 10'b00_1010_0101, 1'b1, 10'h0A5);
        frame("b2", 1'b0, 10'b01_0101_1010, 1'b1, 10'h15A);
        end_frame("b_end");

        // Abort after 5 data bits
        start_frame();
        drive_bit(1'b0);
        for (int i = 0; i < 5; i++) drive_bit(1'b1);
        end_frame("ab");
        chk("ab_data", 32'(bus.rx_data), 32'h15A);
        @(posedge clk);
        #1;
        chk("ab_nv2", 32'(bus.rx_valid), 32'd0);
        start_frame();
        frame("ab_next", 1'b0, 10'b00_1111_1111, 1'b1, 10'h0FF);
        end_frame("ab_next_end");

        // Abort on the same edge as the last data bit
        start_frame();
        drive_bit(1'b0);
        for (int i = 0; i < 9; i++) drive_bit(1'b1);
        @(negedge clk);
        bus.SS_n = 1'b1;
        bus.MOSI = 1'b1;
        @(posedge clk);
        #1;
        chk("ablast_nv", 32'(bus.rx_valid), 32'd0);
        chk("ablast_data", 32'(bus.rx_data), 32'h0FF);
        @(posedge clk);
        start_frame();
        frame("ablast_next", 1'b0, 10'b00_1010_0101, 1'b1, 10'h0A5);
        end_frame("ablast_next_end");

`ifdef SPI_SLAVE_PARITY_EN
        start_frame();
        frame("par_ok", 1'b0, 10'b00_1010_0101, 1'b1, 10'h0A5);
        frame("par_bad", 1'b0, 10'b00_1010_0101, 1'b0, 10'h0A5);
        end_frame("par_end");
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
